// File: rtl/prog_div_clk_pkg.sv
// Shared defaults and constants for the programmable multi-channel clock divider.
package prog_div_clk_pkg;

  localparam int NCH_DEF     = 4;
  localparam int W_DEF       = 16;
  localparam int DIV_RST_DEF = 4;
  localparam int HI_RST_DEF  = 2;

  // Smallest divisor that still yields a toggling output.
  localparam int DIV_MIN     = 2;

endpackage

// File: rtl/prog_div_clk_chan.sv
// One divider channel: counter, active/pending settings, registered clock/tick outputs.
module prog_div_clk_chan
  import prog_div_clk_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DIV_RST = DIV_RST_DEF,
  parameter int HI_RST  = HI_RST_DEF
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_div,
  input  logic [W-1:0] i_hi,
  input  logic         i_sync,
  output logic         o_clk,
  output logic         o_tick,
  output logic         o_pend
);

  localparam logic [W-1:0] DIV_RST_W = W'(DIV_RST);
  localparam logic [W-1:0] HI_RST_W  = W'(HI_RST);
  localparam logic [W-1:0] DIV_MIN_W = W'(DIV_MIN);

  logic [W-1:0] cnt;
  logic [W-1:0] div_a;
  logic [W-1:0] hi_a;
  logic [W-1:0] div_p;
  logic [W-1:0] hi_p;

  logic [W-1:0] div_e;
  logic         wrap;
  logic         apply;
  logic [W-1:0] div_src;
  logic [W-1:0] hi_src;

  // A load in the same cycle as an apply bypasses the pending registers,
  // so a load landing on the wrap takes effect at that wrap.
  always_comb begin
    div_e   = (div_a < DIV_MIN_W) ? DIV_MIN_W : div_a;
    wrap    = i_en && (cnt == (div_e - W'(1)));
    apply   = i_sync || !i_en || wrap;
    div_src = i_load ? i_div : div_p;
    hi_src  = i_load ? i_hi  : hi_p;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt    <= '0;
      div_a  <= DIV_RST_W;
      hi_a   <= HI_RST_W;
      div_p  <= DIV_RST_W;
      hi_p   <= HI_RST_W;
      o_clk  <= 1'b0;
      o_tick <= 1'b0;
      o_pend <= 1'b0;
    end else begin
      cnt <= apply ? '0 : (cnt + W'(1));
      if (i_load) begin
        div_p <= i_div;
        hi_p  <= i_hi;
      end
      if (apply) begin
        div_a <= div_src;
        hi_a  <= hi_src;
      end
      o_pend <= apply ? 1'b0 : (o_pend || i_load);
      o_tick <= i_en && (cnt == '0);
      o_clk  <= i_en && (cnt < hi_a);
    end
  end

endmodule

// File: rtl/prog_div_clk.sv
// Bank of NCH independent programmable clock dividers sharing one clock, reset and sync strobe.
module prog_div_clk
  import prog_div_clk_pkg::*;
#(
  parameter int NCH     = NCH_DEF,
  parameter int W       = W_DEF,
  parameter int DIV_RST = DIV_RST_DEF,
  parameter int HI_RST  = HI_RST_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NCH-1:0]   i_en,
  input  logic [NCH-1:0]   i_load,
  input  logic [NCH*W-1:0] i_div,
  input  logic [NCH*W-1:0] i_hi,
  input  logic             i_sync,
  output logic [NCH-1:0]   o_clk,
  output logic [NCH-1:0]   o_tick,
  output logic [NCH-1:0]   o_pend
);

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    prog_div_clk_chan #(
      .W       (W),
      .DIV_RST (DIV_RST),
      .HI_RST  (HI_RST)
    ) u_chan (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (i_en[k]),
      .i_load (i_load[k]),
      .i_div  (i_div[k*W +: W]),
      .i_hi   (i_hi[k*W +: W]),
      .i_sync (i_sync),
      .o_clk  (o_clk[k]),
      .o_tick (o_tick[k]),
      .o_pend (o_pend[k])
    );
  end

endmodule

// File: tb/tb_prog_div_clk.sv
// Directed bench for prog_div_clk: output waveforms captured as bit vectors and compared to hand-derived patterns.
module tb_prog_div_clk;

  localparam int NCH = 4;
  localparam int W   = 16;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [NCH-1:0]   i_en;
  logic [NCH-1:0]   i_load;
  logic [NCH*W-1:0] i_div;
  logic [NCH*W-1:0] i_hi;
  logic             i_sync;
  logic [NCH-1:0]   o_clk;
  logic [NCH-1:0]   o_tick;
  logic [NCH-1:0]   o_pend;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_tick [NCH];
  logic [31:0] cap_clk  [NCH];
  logic [31:0] cap_pend [NCH];

  prog_div_clk #(.NCH(NCH), .W(W), .DIV_RST(4), .HI_RST(2)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (i_en),
    .i_load (i_load),
    .i_div  (i_div),
    .i_hi   (i_hi),
    .i_sync (i_sync),
    .o_clk  (o_clk),
    .o_tick (o_tick),
    .o_pend (o_pend)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst  = 1'b1;
    i_load = '0;
    i_sync = 1'b0;
    step();
    i_rst  = 1'b0;
  endtask

  // driver tasks
  task automatic set_ch(input int k, input int div, input int hi);
    i_div[k*W +: W] = W'(div);
    i_hi[k*W +: W]  = W'(hi);
  endtask

  task automatic load_step(input logic [NCH-1:0] mask);
    i_load = mask;
    step();
    i_load = '0;
  endtask

  task automatic capture(input int n);
    for (int k = 0; k < NCH; k++) begin
      cap_tick[k] = '0;
      cap_clk[k]  = '0;
      cap_pend[k] = '0;
    end
    for (int i = 0; i < n; i++) begin
      step();
      for (int k = 0; k < NCH; k++) begin
        cap_tick[k][i] = o_tick[k];
        cap_clk[k][i]  = o_clk[k];
        cap_pend[k][i] = o_pend[k];
      end
    end
  endtask

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  initial begin
    i_rst  = 1'b1;
    i_en   = '0;
    i_load = '0;
    i_div  = '0;
    i_hi   = '0;
    i_sync = 1'b0;

    // reset defaults
    step();
    check("rst_clk",  32'(o_clk),  32'h0);
    check("rst_tick", 32'(o_tick), 32'h0);
    check("rst_pend", 32'(o_pend), 32'h0);

    // default divide-by-4, 2 high / 2 low
    i_en = 4'b0001;
    do_reset();
    capture(8);
    check("def_tick", cap_tick[0], 32'h11);
    check("def_clk",  cap_clk[0],  32'h33);

    // load div=10 hi=3 mid-period
    step();
    set_ch(0, 10, 3);
    load_step(4'b0001);
    check("mid_pend", 32'(o_pend[0]), 32'h1);
    capture(16);
    check("mid_tick", cap_tick[0], 32'h1004);
    check("mid_clk",  cap_clk[0],  32'h701C);
    check("mid_pend_seq", cap_pend[0], 32'h0001);

    // clamps and duty extremes, loaded while disabled
    i_en = '0;
    do_reset();
    set_ch(0, 0, 1);
    set_ch(1, 1, 1);
    set_ch(2, 8, 0);
    set_ch(3, 5, 12);
    load_step(4'hF);
    check("dis_pend", 32'(o_pend), 32'h0);
    i_en = 4'hF;
    capture(10);
    check("div0_tick",  cap_tick[0], 32'h155);
    check("div0_clk",   cap_clk[0],  32'h155);
    check("div1_tick",  cap_tick[1], 32'h155);
    check("div1_clk",   cap_clk[1],  32'h155);
    check("hi0_tick",   cap_tick[2], 32'h101);
    check("hi0_clk",    cap_clk[2],  32'h000);
    check("hibig_tick", cap_tick[3], 32'h021);
    check("hibig_clk",  cap_clk[3],  32'h3FF);

    // sync realigns ch0 (div 3, wrapping that cycle) and ch1 (div 7)
    i_en = '0;
    do_reset();
    set_ch(0, 3, 1);
    set_ch(1, 7, 3);
    load_step(4'b0011);
    i_en = 4'b0011;
    for (int i = 0; i < 5; i++) step();
    i_sync = 1'b1;
    step();
    i_sync = 1'b0;
    check("sync_edge", 32'(o_tick[1:0]), 32'h0);
    step();
    check("sync_next", 32'(o_tick[1:0]), 32'h3);
    step();
    check("sync_after", 32'(o_tick[1:0]), 32'h0);

    // last load wins; load on the wrap cycle applies at that wrap
    i_en = 4'b0001;
    do_reset();
    step();
    set_ch(0, 6, 1);
    load_step(4'b0001);
    check("ll_pend1", 32'(o_pend[0]), 32'h1);
    set_ch(0, 9, 2);
    load_step(4'b0001);
    check("ll_pend2", 32'(o_pend[0]), 32'h1);
    step();
    check("ll_pend3", 32'(o_pend[0]), 32'h0);
    capture(12);
    check("ll_tick", cap_tick[0], 32'h201);
    check("ll_clk",  cap_clk[0],  32'h603);
    for (int i = 0; i < 5; i++) step();
    set_ch(0, 3, 1);
    load_step(4'b0001);
    check("wrap_pend", 32'(o_pend[0]), 32'h0);
    capture(6);
    check("wrap_tick", cap_tick[0], 32'h09);
    check("wrap_clk",  cap_clk[0],  32'h09);

    // reset mid-period discards pending load
    i_en = 4'b0001;
    do_reset();
    step();
    step();
    set_ch(0, 10, 3);
    load_step(4'b0001);
    check("rp_pend", 32'(o_pend[0]), 32'h1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("rp_clk",  32'(o_clk),  32'h0);
    check("rp_tick", 32'(o_tick), 32'h0);
    check("rp_pend0", 32'(o_pend), 32'h0);
    capture(12);
    check("rp_tick_seq", cap_tick[0], 32'h111);
    check("rp_clk_seq",  cap_clk[0],  32'h333);
    check("rp_pend_seq", cap_pend[0], 32'h000);

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
